// File: rtl/irq_ctrl.sv
// Programmable interrupt controller: per-source sync, edge/level capture, mask + GIE,
// registered CPU interrupt vector and a 4-word bus register window.
module irq_ctrl #(
  parameter int unsigned N_SRC       = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             sys_rstn,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [31:0]      wd,
  output logic [31:0]      rd,
  input  logic [N_SRC-1:0] irq_src,
  output logic [N_SRC-1:0] ip_out,
  output logic             int_req
);

  localparam logic [1:0] AddrPend = 2'd0;
  localparam logic [1:0] AddrMask = 2'd1;
  localparam logic [1:0] AddrMode = 2'd2;
  localparam logic [1:0] AddrVec  = 2'd3;

  logic [N_SRC-1:0]   sync_q [SYNC_STAGES];
  logic [N_SRC-1:0]   prev_q;
  logic [SYNC_STAGES:0] warm_q;
  logic [N_SRC-1:0]   pend_q, pend_d;
  logic [N_SRC-1:0]   mask_q, mask_d;
  logic [N_SRC-1:0]   mode_q, mode_d;
  logic               gie_q, gie_d;
  logic [N_SRC-1:0]   ip_q, ip_d;
  logic               req_q, req_d;

  logic [N_SRC-1:0]   sync_out;
  logic [N_SRC-1:0]   edge_ev;
  logic [N_SRC-1:0]   pend_clr;
  logic [N_SRC-1:0]   active;
  logic               mode_we;
  logic [2:0]         vec_idx;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Edges are suppressed until prev has caught up with a fully primed chain, so a source
  // held high through reset release never looks like a fresh edge.
  assign edge_ev  = sync_out & ~prev_q & {N_SRC{warm_q[SYNC_STAGES]}};

  assign mode_we  = we && (addr == AddrMode);
  assign pend_clr = (we && (addr == AddrPend)) ? wd[N_SRC-1:0] : '0;
  assign active   = pend_q & mask_q;

  always_comb begin
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (mode_we) begin
        pend_d[i] = 1'b0;
      end else if (mode_q[i]) begin
        pend_d[i] = sync_out[i];
      end else begin
        pend_d[i] = edge_ev[i] | (pend_q[i] & ~pend_clr[i]);
      end
    end
  end

  always_comb begin
    mask_d = mask_q;
    gie_d  = gie_q;
    mode_d = mode_q;
    if (we && (addr == AddrMask)) begin
      mask_d = wd[N_SRC-1:0];
      gie_d  = wd[31];
    end
    if (mode_we) begin
      mode_d = wd[N_SRC-1:0];
    end
    ip_d  = active & {N_SRC{gie_q}};
    req_d = (|active) & gie_q;
  end

  // Fixed priority: scan downwards so the lowest active index wins.
  always_comb begin
    vec_idx = 3'd0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (active[i]) begin
        vec_idx = 3'(i);
      end
    end
  end

  always_comb begin
    rd = '0;
    unique case (addr)
      AddrPend: rd[N_SRC-1:0] = pend_q;
      AddrMask: begin
        rd[N_SRC-1:0] = mask_q;
        rd[31]        = gie_q;
      end
      AddrMode: rd[N_SRC-1:0] = mode_q;
      AddrVec: begin
        if (|active) begin
          rd[31]  = 1'b1;
          rd[2:0] = vec_idx;
        end
      end
      default: rd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= '0;
      end
      prev_q <= '0;
      warm_q <= '0;
      pend_q <= '0;
      mask_q <= '0;
      mode_q <= '0;
      gie_q  <= 1'b0;
      ip_q   <= '0;
      req_q  <= 1'b0;
    end else begin
      sync_q[0] <= irq_src;
      for (int s = 1; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q <= sync_out;
      warm_q <= {warm_q[SYNC_STAGES-1:0], 1'b1};
      pend_q <= pend_d;
      mask_q <= mask_d;
      mode_q <= mode_d;
      gie_q  <= gie_d;
      ip_q   <= ip_d;
      req_q  <= req_d;
    end
  end

  assign ip_out  = ip_q;
  assign int_req = req_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed table-driven bench for irq_ctrl: one record per clock, checked after the edge.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        sys_rstn;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic [5:0]  irq_src;
  logic [5:0]  ip_out;
  logic        int_req;

  int total = 0;
  int bad   = 0;

  irq_ctrl #(.N_SRC(6), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .sys_rstn(sys_rstn),
    .we      (we),
    .addr    (addr),
    .wd      (wd),
    .rd      (rd),
    .irq_src (irq_src),
    .ip_out  (ip_out),
    .int_req (int_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [5:0]  src;
    logic [31:0] rd;
    logic [5:0]  ip;
    logic        req;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic w, logic [1:0] a, logic [31:0] d, logic [5:0] s,
                              logic [31:0] r, logic [5:0] ip, logic rq);
    vec_t v;
    v.we = w; v.addr = a; v.wd = d; v.src = s; v.rd = r; v.ip = ip; v.req = rq;
    vecs.push_back(v);
  endfunction

  task automatic chk32(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  initial begin
    // Release with all sources high: no edge. Then 1-clk pulse on src0.
    add(0, 0, 0, 6'h3F, 32'h0, 6'h00, 0);
    add(0, 0, 0, 6'h3F, 32'h0, 6'h00, 0);
    add(0, 0, 0, 6'h3F, 32'h0, 6'h00, 0);
    add(0, 0, 0, 6'h3F, 32'h0, 6'h00, 0);
    add(1, 1, 32'h8000_0001, 6'h00, 32'h8000_0001, 6'h00, 0);
    add(0, 0, 0, 6'h00, 32'h0, 6'h00, 0);
    add(0, 0, 0, 6'h00, 32'h0, 6'h00, 0);
    add(0, 0, 0, 6'h01, 32'h0, 6'h00, 0);                // E1
    add(0, 0, 0, 6'h00, 32'h0, 6'h00, 0);                // E2
    add(0, 0, 0, 6'h00, 32'h1, 6'h00, 0);                // E3: pend
    add(0, 3, 0, 6'h00, 32'h8000_0000, 6'h01, 1);        // E4: ip_out
    add(1, 0, 32'h1, 6'h00, 32'h0, 6'h01, 1);
    add(0, 0, 0, 6'h00, 32'h0, 6'h00, 0);
    // Simultaneous src1 + src3, priority walk via W1C.
    add(1, 1, 32'h8000_000E, 6'h0A, 32'h8000_000E, 6'h00, 0);
    add(0, 3, 0, 6'h0A, 32'h0, 6'h00, 0);
    add(0, 3, 0, 6'h0A, 32'h8000_0001, 6'h00, 0);
    add(1, 0, 32'h2, 6'h00, 32'h8, 6'h0A, 1);
    add(0, 3, 0, 6'h00, 32'h8000_0003, 6'h08, 1);
    add(1, 0, 32'h8, 6'h00, 32'h0, 6'h08, 1);
    add(0, 3, 0, 6'h00, 32'h0, 6'h00, 0);
    // Edge on src2 in the same cycle as its W1C: set wins.
    add(0, 0, 0, 6'h04, 32'h0, 6'h00, 0);
    add(0, 0, 0, 6'h04, 32'h0, 6'h00, 0);
    add(1, 0, 32'h4, 6'h04, 32'h4, 6'h00, 0);
    add(0, 0, 0, 6'h04, 32'h4, 6'h04, 1);
    add(1, 0, 32'h4, 6'h00, 32'h0, 6'h04, 1);
    add(0, 0, 0, 6'h00, 32'h0, 6'h00, 0);
    // Level mode on src4 with GIE gating.
    add(1, 2, 32'h10, 6'h10, 32'h10, 6'h00, 0);
    add(1, 1, 32'h10, 6'h10, 32'h10, 6'h00, 0);
    add(0, 0, 0, 6'h10, 32'h10, 6'h00, 0);
    add(1, 0, 32'h10, 6'h10, 32'h10, 6'h00, 0);
    add(0, 3, 0, 6'h10, 32'h8000_0004, 6'h00, 0);
    add(1, 1, 32'h8000_0010, 6'h10, 32'h8000_0010, 6'h00, 0);
    add(0, 0, 0, 6'h10, 32'h10, 6'h10, 1);
    add(0, 0, 0, 6'h00, 32'h10, 6'h10, 1);
    add(0, 0, 0, 6'h00, 32'h10, 6'h10, 1);
    add(0, 0, 0, 6'h00, 32'h0, 6'h10, 1);
    add(0, 0, 0, 6'h00, 32'h0, 6'h00, 0);
    // Back to edge mode, fill all pend bits.
    add(1, 2, 32'h0, 6'h00, 32'h0, 6'h00, 0);
    add(1, 1, 32'h8000_003F, 6'h3F, 32'h8000_003F, 6'h00, 0);
    add(0, 0, 0, 6'h3F, 32'h0, 6'h00, 0);
    add(0, 0, 0, 6'h3F, 32'h3F, 6'h00, 0);
    add(0, 3, 0, 6'h3F, 32'h8000_0000, 6'h3F, 1);

    sys_rstn = 1'b0;
    we       = 1'b0;
    addr     = 2'd0;
    wd       = '0;
    irq_src  = 6'h3F;
    repeat (2) @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      chk32($sformatf("rst_rd%0d", a), rd, 32'h0);
    end
    chk32("rst_ip", {26'h0, ip_out}, 32'h0);
    chk32("rst_req", {31'h0, int_req}, 32'h0);

    @(negedge clk);
    sys_rstn = 1'b1;
    for (int k = 0; k < vecs.size(); k++) begin
      we      = vecs[k].we;
      addr    = vecs[k].addr;
      wd      = vecs[k].wd;
      irq_src = vecs[k].src;
      @(negedge clk);
      chk32($sformatf("v%0d_rd", k), rd, vecs[k].rd);
      chk32($sformatf("v%0d_ip", k), {26'h0, ip_out}, {26'h0, vecs[k].ip});
      chk32($sformatf("v%0d_req", k), {31'h0, int_req}, {31'h0, vecs[k].req});
    end

    // Asynchronous reset between edges clears everything without a clock edge.
    we = 1'b0;
    #2;
    sys_rstn = 1'b0;
    #1;
    chk32("arst_ip", {26'h0, ip_out}, 32'h0);
    chk32("arst_req", {31'h0, int_req}, 32'h0);
    chk32("arst_vec", rd, 32'h0);
    addr = 2'd1;
    #1;
    chk32("arst_mask", rd, 32'h0);
    addr = 2'd0;
    #1;
    chk32("arst_pend", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
